sudoku_irq_hub: RTL and testbench

Parametrised interrupt aggregator on the management Wishbone bus. It replaces the fixed one-to-one wiring of accelerator and UART interrupt lines to user_irq. It collects NUM_SRC interrupt sources (accelerator cores, UARTs, timers) and applies per-source enable, level/edge mode, pending latching with write-1-to-clear, software force and per-source routing. The result drives NUM_OUT outputs, normally user_irq[2:0].

---
 rtl/sudoku_irq_hub.sv | 182 ++++++++++++++++++
 tb/tb_sudoku_irq_hub.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_irq_hub.sv
// sudoku_irq_hub: Wishbone interrupt aggregator.
// Latches, masks and routes NUM_SRC sources onto NUM_OUT lines.
module sudoku_irq_hub #(
    parameter int          NUM_SRC     = 8,
    parameter int          NUM_OUT     = 3,
    parameter int          SYNC_STAGES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0800,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFE0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic [31:0]        wb_dat_o,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [NUM_OUT-1:0] irq_o
);

    localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << NUM_SRC) - 32'd1);
    localparam logic [63:0] RT_MASK  = (NUM_SRC >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF
                                     : ((64'd1 << (2 * NUM_SRC)) - 64'd1);
    localparam logic [31:0] ID_WORD  = {16'h5D1A, 8'(NUM_SRC), 8'(NUM_OUT)};

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_PEND   = 3'd1;
    localparam logic [2:0] OFF_EN     = 3'd2;
    localparam logic [2:0] OFF_MODE   = 3'd3;
    localparam logic [2:0] OFF_ROUTE0 = 3'd4;
    localparam logic [2:0] OFF_ROUTE1 = 3'd5;
    localparam logic [2:0] OFF_FORCE  = 3'd6;
    localparam logic [2:0] OFF_ID     = 3'd7;

    logic [NUM_SRC-1:0] s_lvl;
    logic [31:0]        s32;
    logic [31:0]        prev_q;
    logic [31:0]        rise32;
    logic [31:0]        pend_q;
    logic [31:0]        en_q;
    logic [31:0]        mode_q;
    logic [63:0]        route_q;
    logic [31:0]        pend_nxt;
    logic [31:0]        w1c;
    logic [31:0]        frc;
    logic [31:0]        bmask;
    logic [31:0]        wval;
    logic [31:0]        rdata;
    logic [2:0]         off;
    logic               hit;
    logic               acc;
    logic               wr;
    logic               rd;
    logic [NUM_OUT-1:0] irq_nxt;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_lvl = irq_src;
        end else begin : g_sync
            logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
            // Resynchronise asynchronous sources into wb_clk_i.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
                end else begin
                    sync_q[0] <= irq_src;
                    for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
                end
            end
            assign s_lvl = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign s32    = 32'(s_lvl);
    assign rise32 = s32 & ~prev_q;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] val,
                                          input logic [31:0] msk);
        return (old & ~msk) | val;
    endfunction

    // Bus decode: one access per ack, writes masked by byte lanes.
    always_comb begin
        hit   = wb_cyc_i & wb_stb_i & ((wb_adr_i & ADDR_MASK) == BASE_ADDR);
        acc   = hit & ~wb_ack_o;
        wr    = acc & wb_we_i;
        rd    = acc & ~wb_we_i;
        off   = wb_adr_i[4:2];
        bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                 {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wval  = wb_dat_i & bmask;
        w1c   = (wr && off == OFF_PEND)  ? (wval & SRC_MASK) : 32'd0;
        frc   = (wr && off == OFF_FORCE) ? (wval & SRC_MASK) : 32'd0;
    end

    // Pending: a new set event always wins over a same-cycle clear.
    always_comb begin
        pend_nxt = (((mode_q & rise32) | (~mode_q & s32) | frc) & SRC_MASK)
                 | (pend_q & ~w1c);
    end

    // Read mux for the register window.
    always_comb begin
        rdata = 32'd0;
        unique case (off)
            OFF_STATUS: rdata = s32 & SRC_MASK;
            OFF_PEND:   rdata = pend_q;
            OFF_EN:     rdata = en_q;
            OFF_MODE:   rdata = mode_q;
            OFF_ROUTE0: rdata = route_q[31:0];
            OFF_ROUTE1: rdata = route_q[63:32];
            OFF_FORCE:  rdata = 32'd0;
            OFF_ID:     rdata = ID_WORD;
            default:    rdata = 32'd0;
        endcase
    end

    // Output lines: enabled pending sources OR-ed onto their route.
    always_comb begin
        irq_nxt = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pend_q[i] && en_q[i] && route_q[2*i +: 2] == 2'(k)) begin
                    irq_nxt[k] = 1'b1;
                end
            end
        end
    end

    // Ack pulse and registered read data, both cleared when idle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= rd ? rdata : 32'd0;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q    <= 32'd0;
            mode_q  <= 32'd0;
            route_q <= 64'd0;
        end else if (wr) begin
            case (off)
                OFF_EN:     en_q   <= merge(en_q, wval, bmask) & SRC_MASK;
                OFF_MODE:   mode_q <= merge(mode_q, wval, bmask) & SRC_MASK;
                OFF_ROUTE0: route_q[31:0] <=
                    merge(route_q[31:0], wval, bmask) & RT_MASK[31:0];
                OFF_ROUTE1: route_q[63:32] <=
                    merge(route_q[63:32], wval, bmask) & RT_MASK[63:32];
                default: ;
            endcase
        end
    end

    // Pending latches and edge history.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pend_q <= 32'd0;
            prev_q <= 32'd0;
        end else begin
            pend_q <= pend_nxt;
            prev_q <= s32;
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_o <= '0;
        else          irq_o <= irq_nxt;
    end

endmodule

// File: tb/tb_sudoku_irq_hub.sv
// tb_sudoku_irq_hub: directed plus randomized bench
// against a per-source behavioural model.
module tb_sudoku_irq_hub;

    localparam logic [31:0] BASE = 32'h3000_0800;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  src;
    logic [2:0]  irq;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_pend [8];
    bit          m_en   [8];
    bit          m_mode [8];
    bit          m_prev [8];
    int          m_route[8];
    bit          m_ack;
    logic [31:0] m_dat;
    logic [2:0]  m_irq;

    always #5 clk = ~clk;

    sudoku_irq_hub dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_ack_o (ack),
        .wb_dat_o (dat_o),
        .irq_src  (src),
        .irq_o    (irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int off);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 8; i++) begin
            case (off)
                0: v[i] = src[i];
                1: v[i] = m_pend[i];
                2: v[i] = m_en[i];
                3: v[i] = m_mode[i];
                4: v = v | (32'(m_route[i]) << (2 * i));
                default: ;
            endcase
        end
        if (off == 7) v = 32'h5D1A_0803;
        return v;
    endfunction

    task automatic model_step();
        bit          hit;
        bit          acc;
        bit          wr;
        bit          lane;
        bit          b;
        bit          set;
        bit          frc;
        bit          clr;
        bit          np;
        int          off;
        logic [2:0]  nirq;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0;
                m_prev[i] = 0; m_route[i] = 0;
            end
            m_ack = 0; m_dat = 32'd0; m_irq = 3'd0;
            return;
        end
        hit  = cyc && stb && ((adr & 32'hFFFF_FFE0) == BASE);
        acc  = hit && !m_ack;
        wr   = acc && we;
        off  = int'(adr[4:2]);
        nirq = 3'd0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++)
                if (m_pend[i] && m_en[i] && m_route[i] == k) nirq[k] = 1'b1;
        m_dat = (acc && !we) ? m_read(off) : 32'd0;
        for (int i = 0; i < 8; i++) begin
            lane = sel[i / 8];
            b    = dat_i[i];
            set  = m_mode[i] ? (src[i] && !m_prev[i]) : src[i];
            frc  = wr && off == 6 && lane && b;
            clr  = wr && off == 1 && lane && b;
            np   = set || frc || (m_pend[i] && !clr);
            if (wr && lane && off == 2) m_en[i] = b;
            if (wr && lane && off == 3) m_mode[i] = b;
            if (wr && off == 4 && sel[(2 * i) / 8])
                m_route[i] = int'((dat_i >> (2 * i)) & 32'd3);
            m_prev[i] = src[i];
            m_pend[i] = np;
        end
        m_irq = nirq;
        m_ack = acc;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("irq", 32'(irq), 32'(m_irq));
        check("ack", 32'(ack), 32'(m_ack));
        check("dat", dat_o, m_dat);
    endtask

    task automatic wb_rw(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic w,
                         output logic [31:0] r);
        adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        cycle();
        check("ack_lat", 32'(ack), 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        logic [31:0] r;
        wb_rw(BASE + 32'(off), d, 4'hF, 1'b1, r);
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] r);
        wb_rw(BASE + 32'(off), 32'd0, 4'hF, 1'b0, r);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; adr = 32'd0; dat_i = 32'd0; sel = 4'h0;
        we = 1'b0; cyc = 1'b0; stb = 1'b0; src = 8'd0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("rst_irq", 32'(irq), 32'd0);

        rd(5'h1C, r);
        check("id", r, 32'h5D1A_0803);
        for (int o = 0; o < 7; o++) begin
            rd(5'(o * 4), r);
            check("rst_reg", r, 32'd0);
        end

        wr(5'h08, 32'h01);
        wr(5'h10, 32'h00);
        src[0] = 1'b1;
        cycle();
        check("lvl_lat1", 32'(irq), 32'd0);
        cycle();
        check("lvl_irq", 32'(irq), 32'd1);
        wr(5'h04, 32'h01);
        rd(5'h04, r);
        check("lvl_w1c_hi", r, 32'h01);
        src[0] = 1'b0;
        wr(5'h04, 32'h01);
        rd(5'h04, r);
        check("lvl_w1c_lo", r, 32'h00);
        check("lvl_irq_off", 32'(irq), 32'd0);

        wr(5'h0C, 32'h08);
        wr(5'h08, 32'h08);
        wr(5'h10, 32'h80);
        src[3] = 1'b1;
        cycle();
        src[3] = 1'b0;
        cycle();
        cycle();
        check("edge_irq", 32'(irq), 32'h4);
        rd(5'h04, r);
        check("edge_pend", r, 32'h08);
        src[3] = 1'b1;
        wr(5'h04, 32'h08);
        src[3] = 1'b0;
        rd(5'h04, r);
        check("edge_set_wins", r, 32'h08);

        wr(5'h08, 32'h00);
        wr(5'h04, 32'hFF);
        wr(5'h18, 32'h20);
        rd(5'h04, r);
        check("force_pend", r, 32'h20);
        check("force_irq", 32'(irq), 32'd0);
        rd(5'h18, r);
        check("force_rd", r, 32'd0);
        wr(5'h10, 32'hC00);
        wr(5'h08, 32'h20);
        cycle();
        check("unrouted", 32'(irq), 32'd0);
        wr(5'h10, 32'h400);
        cycle();
        check("route1", 32'(irq), 32'h2);

        wr(5'h08, 32'h00);
        wb_rw(BASE + 32'h08, 32'hFFFF_FFFF, 4'b0010, 1'b1, r);
        rd(5'h08, r);
        check("lane_en", r, 32'h00);
        adr = 32'h3000_0900; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        cycle();
        check("miss_ack0", 32'(ack), 32'd0);
        cycle();
        check("miss_ack1", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        cycle();

        wr(5'h0C, 32'h00);
        wr(5'h04, 32'hFF);
        wr(5'h10, 32'h24);
        wr(5'h08, 32'h07);
        wr(5'h18, 32'h07);
        cycle();
        check("all_lines", 32'(irq), 32'h7);
        rst = 1'b1; adr = BASE + 32'h1C; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        cycle();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq2", 32'(irq), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        cycle();

        for (int n = 0; n < 2000; n++) begin
            cyc = ($urandom_range(0, 3) != 0);
            stb = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) adr = $urandom();
            else adr = BASE + 32'($urandom_range(0, 31));
            we    = $urandom_range(0, 1) == 1;
            sel   = 4'($urandom());
            dat_i = $urandom();
            if ($urandom_range(0, 1) == 1) dat_i = dat_i & 32'h0000_FFFF;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 5) == 0) src[i] = ~src[i];
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
